uart_cfg_ctrl: RTL and testbench
================================

# uart_cfg_ctrl

APB-master configuration sequencer for the 16550-style `uart_top` register port. On a single start pulse it latches a UART setup (baud divisor, line format, FIFO, interrupt-enable and modem-control values) and issues the fixed register write sequence needed to bring the UART up, reporting done or error. It sits between the SoC boot/test controller and the UART APB slave, so software and testbenches do not hand-sequence the DLAB-protected divisor accesses.

## Interface
- `ADDR_W`, default 8: APB address width.
- `REG_STRIDE`, default 4: byte stride between UART registers; address = offset × stride.
- `TIMEOUT`, default 16: maximum ACCESS cycles waiting for `pready` (must be 2..255).

- `clk`  in  1  single block clock; the APB bus is also clocked by it.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_start`  in  1  request pulse; sampled only in IDLE.
- `cfg_div`  in  16  baud divisor, DLM:DLL.
- `cfg_lcr`  in  6  LCR[5:0]: word length, stop bits, parity.
- `cfg_fcr`  in  8  FCR value.
- `cfg_ier`  in  4  IER[3:0].
- `cfg_mcr`  in  5  MCR[4:0].
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky error; cleared by the next accepted start.
- `err_code`  out  2  01 `pslverr`, 10 timeout, 11 read-back mismatch.
- `err_step`  out  3  step index that failed.
- `psel`, `penable`, `pwrite`  out  1  APB control.
- `paddr`  out  ADDR_W  APB address.
- `pwdata`  out  32  write data; bits [31:8] are zero.
- `prdata`  in  32  read data; only [7:0] is used.
- `pready`, `pslverr`  in  1  APB response.

## Operation
- Steps 0..6, fixed order, with register offsets:
  - step 0: LCR (3) ← 0x80 | lcr
  - step 1: DLL (0) ← div[7:0]
  - step 2: DLM (1) ← div[15:8]
  - step 3: LCR ← {2'b00, lcr}
  - step 4: FCR (2) ← fcr
  - step 5: IER (1) ← ier
  - step 6: MCR (4) ← mcr
- States: IDLE, SETUP, ACCESS, DONE, ABORT.
  - IDLE → SETUP on `cfg_start`. All cfg_* inputs are latched that cycle; step = 0; `err` is cleared.
  - SETUP → ACCESS unconditionally.
  - In ACCESS with `pready`:
    - `pslverr` → ABORT, code 01.
    - last transfer of step 6 → DONE.
    - otherwise → SETUP of the next transfer.
  - ACCESS with a full TIMEOUT count and no `pready` → ABORT, code 10.
  - DONE and ABORT → IDLE after one cycle.
- `cfg_start` while busy is ignored and not queued.
- Reset mid-sequence abandons the sequence. The UART is left partially configured, and software must restart.

## Timing
- Reset values: `busy`, `done`, `err`, `err_code`, `err_step`, `psel`, `penable`, `pwrite`, `paddr`, `pwdata` are all 0.
- `busy` is high from the cycle after the start is accepted through the DONE/ABORT cycle.
- Each transfer is SETUP (`psel`=1, `penable`=0) followed by ACCESS (`penable`=1) until `pready`.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through the completing ACCESS.
- Back-to-back transfers: the next SETUP starts the cycle after `pready`, with no idle cycle.
- Minimum sequence with zero wait states: 14 APB cycles. `done` pulses in the cycle after the final `pready`.
- The timeout counter resets on every SETUP. ABORT is entered on the cycle where the count reaches TIMEOUT with `pready` low; `psel` and `penable` drop in that ABORT cycle.
- `err`, `err_code` and `err_step` update in the ABORT cycle and hold until the next accepted start.

## Configuration
- Macro `UART_CFG_READBACK_EN`.
- Defined:
  - Every step except step 4 (FCR is write-only; its offset reads IIR) is followed by a read of the same address.
  - `prdata[7:0]` is compared with the written value; unused high bits of IER and MCR are masked to 0.
  - A mismatch → ABORT, code 11, with `err_step` = that step.
  - The read transfer has the same SETUP/ACCESS timing as a write. Minimum sequence: 26 cycles.
- Undefined: writes only, and code 11 is never produced.

## Structure
- Package `uart_cfg_pkg` holds:
  - the state enum;
  - register offset constants (LCR, DLL, DLM, FCR, IER, MCR);
  - the DLAB bit constant;
  - the step count (7);
  - the err_code constants.
- Sub-module `uart_cfg_apb_xfer` is a single-transfer APB engine.
  - Request: start, write, addr, wdata.
  - Response: complete, slverr, timeout, rdata.
  - It owns the SETUP/ACCESS phasing and the timeout counter.
  - The top level owns the step sequencing and the read-back compare.

## Test plan
- div=0x0036, lcr=0x03, fcr=0xC7, ier=0x5, mcr=0x03, zero-wait slave → exact writes to offsets 3,0,1,3,2,1,4 with data 0x83,0x36,0x00,0x03,0xC7,0x05,0x03; `done` at cycle 15 after start; `err`=0.
- Slave inserts 3 wait states on step 2 → `paddr`/`pwdata` are held stable throughout; the sequence completes; total is 17 cycles.
- `pslverr` on step 5 → ABORT; `err`=1, `err_code`=01, `err_step`=5; no MCR write is issued; the next start clears `err`.
- `pready` never asserted on step 0, TIMEOUT=16 → `err_code`=10, `err_step`=0; `psel` drops after 16 ACCESS cycles.
- With `UART_CFG_READBACK_EN`, slave returns 0x37 for DLL → `err_code`=11, `err_step`=1. Separately, `rst` asserted during step 3 → all outputs are 0 immediately, and a fresh start restarts at step 0.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART configuration sequencer.
// The UART_CFG_READBACK_EN build option uses the same definitions.
package uart_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE,
      ST_ABORT
   } cfg_state_e;

   typedef enum logic [1:0] {
      XF_IDLE,
      XF_SETUP,
      XF_ACCESS
   } xfer_phase_e;

   localparam logic [2:0] OFF_DLL = 3'd0;
   localparam logic [2:0] OFF_DLM = 3'd1;
   localparam logic [2:0] OFF_IER = 3'd1;
   localparam logic [2:0] OFF_FCR = 3'd2;
   localparam logic [2:0] OFF_LCR = 3'd3;
   localparam logic [2:0] OFF_MCR = 3'd4;

   localparam logic [7:0] LCR_DLAB = 8'h80;

   localparam int         NUM_STEPS = 7;
   localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);
   localparam logic [2:0] STEP_FCR  = 3'd4;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_SLVERR   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_READBACK = 2'b11;

   function automatic logic [2:0] step_offset(input logic [2:0] step);
      logic [2:0] off;
      off = OFF_MCR;
      case (step)
         3'd0:    off = OFF_LCR;
         3'd1:    off = OFF_DLL;
         3'd2:    off = OFF_DLM;
         3'd3:    off = OFF_LCR;
         3'd4:    off = OFF_FCR;
         3'd5:    off = OFF_IER;
         default: off = OFF_MCR;
      endcase
      return off;
   endfunction

   function automatic logic [7:0] step_wdata(input logic [2:0]  step,
                                             input logic [15:0] div,
                                             input logic [5:0]  lcr,
                                             input logic [7:0]  fcr,
                                             input logic [3:0]  ier,
                                             input logic [4:0]  mcr);
      logic [7:0] data;
      data = {3'b000, mcr};
      case (step)
         3'd0:    data = LCR_DLAB | {2'b00, lcr};
         3'd1:    data = div[7:0];
         3'd2:    data = div[15:8];
         3'd3:    data = {2'b00, lcr};
         3'd4:    data = fcr;
         3'd5:    data = {4'b0000, ier};
         default: data = {3'b000, mcr};
      endcase
      return data;
   endfunction

   // IER and MCR read back with undefined upper bits; ignore them.
   function automatic logic [7:0] step_mask(input logic [2:0] step);
      logic [7:0] mask;
      mask = 8'hFF;
      case (step)
         3'd5:    mask = 8'h0F;
         3'd6:    mask = 8'h1F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/uart_cfg_apb_xfer.sv
// Single-transfer APB master engine: SETUP/ACCESS phasing, request latching
// and the ACCESS-phase timeout counter.
module uart_cfg_apb_xfer
   import uart_cfg_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic              complete,
   output logic              slverr,
   output logic              timeout,
   output logic [7:0]        rdata,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [31:0]       pwdata,
   input  logic [7:0]        prdata,
   input  logic              pready,
   input  logic              pslverr
);

   xfer_phase_e       phase_reg, phase_next;
   logic [7:0]        cnt_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [7:0]        wdata_reg;
   logic              write_reg;
   logic              accept;

   assign complete = (phase_reg == XF_ACCESS) && pready;
   assign slverr   = complete && pslverr;
   assign timeout  = (phase_reg == XF_ACCESS) && !pready && (cnt_reg == 8'(TIMEOUT - 1));
   assign rdata    = prdata;

   // A new request is taken when idle or in the completing ACCESS cycle,
   // which gives back-to-back transfers with no idle cycle between them.
   assign accept = start && ((phase_reg == XF_IDLE) || complete);

   always_comb begin
      phase_next = phase_reg;
      case (phase_reg)
         XF_IDLE:   if (start) phase_next = XF_SETUP;
         XF_SETUP:  phase_next = XF_ACCESS;
         XF_ACCESS: begin
            if (pready)       phase_next = start ? XF_SETUP : XF_IDLE;
            else if (timeout) phase_next = XF_IDLE;
         end
         default:   phase_next = XF_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_reg <= XF_IDLE;
         cnt_reg   <= 8'd0;
         addr_reg  <= '0;
         wdata_reg <= 8'd0;
         write_reg <= 1'b0;
      end else begin
         phase_reg <= phase_next;
         if (phase_reg == XF_SETUP)
            cnt_reg <= 8'd0;
         else if (phase_reg == XF_ACCESS)
            cnt_reg <= cnt_reg + 8'd1;
         if (accept) begin
            addr_reg  <= addr;
            wdata_reg <= write ? wdata : 8'd0;
            write_reg <= write;
         end
      end
   end

   assign psel    = (phase_reg != XF_IDLE);
   assign penable = (phase_reg == XF_ACCESS);
   assign pwrite  = write_reg;
   assign paddr   = addr_reg;
   assign pwdata  = {24'd0, wdata_reg};

endmodule

// File: rtl/uart_cfg_ctrl.sv
// APB configuration sequencer for a 16550-style UART: issues the fixed
// bring-up write sequence. Define UART_CFG_READBACK_EN to verify each write.
module uart_cfg_ctrl
   import uart_cfg_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int REG_STRIDE = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic [15:0]       cfg_div,
   input  logic [5:0]        cfg_lcr,
   input  logic [7:0]        cfg_fcr,
   input  logic [3:0]        cfg_ier,
   input  logic [4:0]        cfg_mcr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [2:0]        err_step,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [31:0]       pwdata,
   input  logic [31:0]       prdata,
   input  logic              pready,
   input  logic              pslverr
);

   cfg_state_e        state_reg, state_next;
   logic [2:0]        step_reg, step_next;
   logic              rd_reg, rd_next;
   logic [15:0]       div_reg;
   logic [5:0]        lcr_reg;
   logic [7:0]        fcr_reg;
   logic [3:0]        ier_reg;
   logic [4:0]        mcr_reg;
   logic              err_reg;
   logic [1:0]        err_code_reg;
   logic [2:0]        err_step_reg;
   logic [1:0]        abort_code;

   logic              x_start, x_write;
   logic [ADDR_W-1:0] x_addr;
   logic [7:0]        x_wdata;
   logic              x_complete, x_slverr, x_timeout;
   logic [7:0]        x_rdata;
   logic [2:0]        step_inc;

   function automatic logic [ADDR_W-1:0] step_addr(input logic [2:0] step);
      return ADDR_W'(32'(step_offset(step)) * 32'(REG_STRIDE));
   endfunction

   assign step_inc = step_reg + 3'd1;

   always_comb begin
      state_next = state_reg;
      step_next  = step_reg;
      rd_next    = rd_reg;
      x_start    = 1'b0;
      x_write    = 1'b1;
      x_addr     = step_addr(step_reg);
      x_wdata    = 8'd0;
      abort_code = ERR_NONE;
      case (state_reg)
         ST_IDLE: begin
            if (cfg_start) begin
               state_next = ST_SETUP;
               step_next  = 3'd0;
               rd_next    = 1'b0;
               x_start    = 1'b1;
               x_addr     = step_addr(3'd0);
               x_wdata    = step_wdata(3'd0, cfg_div, cfg_lcr, cfg_fcr, cfg_ier, cfg_mcr);
            end
         end
         ST_SETUP: state_next = ST_ACCESS;
         ST_ACCESS: begin
            if (x_timeout) begin
               state_next = ST_ABORT;
               abort_code = ERR_TIMEOUT;
            end else if (x_complete) begin
               if (x_slverr) begin
                  state_next = ST_ABORT;
                  abort_code = ERR_SLVERR;
               end
`ifdef UART_CFG_READBACK_EN
               else if (rd_reg && ((x_rdata & step_mask(step_reg)) !=
                        step_wdata(step_reg, div_reg, lcr_reg, fcr_reg, ier_reg, mcr_reg))) begin
                  state_next = ST_ABORT;
                  abort_code = ERR_READBACK;
               end else if (!rd_reg && (step_reg != STEP_FCR)) begin
                  // FCR shares its offset with IIR, so it cannot be read back.
                  state_next = ST_SETUP;
                  rd_next    = 1'b1;
                  x_start    = 1'b1;
                  x_write    = 1'b0;
               end
`endif
               else if (step_reg == LAST_STEP) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_SETUP;
                  step_next  = step_inc;
                  rd_next    = 1'b0;
                  x_start    = 1'b1;
                  x_addr     = step_addr(step_inc);
                  x_wdata    = step_wdata(step_inc, div_reg, lcr_reg, fcr_reg, ier_reg, mcr_reg);
               end
            end
         end
         ST_DONE:  state_next = ST_IDLE;
         ST_ABORT: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         step_reg     <= 3'd0;
         rd_reg       <= 1'b0;
         div_reg      <= 16'd0;
         lcr_reg      <= 6'd0;
         fcr_reg      <= 8'd0;
         ier_reg      <= 4'd0;
         mcr_reg      <= 5'd0;
         err_reg      <= 1'b0;
         err_code_reg <= ERR_NONE;
         err_step_reg <= 3'd0;
      end else begin
         state_reg <= state_next;
         step_reg  <= step_next;
         rd_reg    <= rd_next;
         if ((state_reg == ST_IDLE) && cfg_start) begin
            div_reg      <= cfg_div;
            lcr_reg      <= cfg_lcr;
            fcr_reg      <= cfg_fcr;
            ier_reg      <= cfg_ier;
            mcr_reg      <= cfg_mcr;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
            err_step_reg <= 3'd0;
         end else if ((state_reg == ST_ACCESS) && (state_next == ST_ABORT)) begin
            err_reg      <= 1'b1;
            err_code_reg <= abort_code;
            err_step_reg <= step_reg;
         end
      end
   end

   uart_cfg_apb_xfer #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) u_xfer (
      .clk      (clk),
      .rst      (rst),
      .start    (x_start),
      .write    (x_write),
      .addr     (x_addr),
      .wdata    (x_wdata),
      .complete (x_complete),
      .slverr   (x_slverr),
      .timeout  (x_timeout),
      .rdata    (x_rdata),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata[7:0]),
      .pready   (pready),
      .pslverr  (pslverr)
   );

   assign busy     = (state_reg != ST_IDLE);
   assign done     = (state_reg == ST_DONE);
   assign err      = err_reg;
   assign err_code = err_code_reg;
   assign err_step = err_step_reg;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Self-checking bench for uart_cfg_ctrl with a behavioural APB slave and a
// transfer scoreboard; also covers the UART_CFG_READBACK_EN build.
module tb_uart_cfg_ctrl;

`ifdef UART_CFG_READBACK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif

   typedef struct packed {
      logic        w;
      logic [7:0]  addr;
      logic [31:0] data;
   } xfer_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_start = 1'b0;
   logic [15:0] cfg_div = 16'h0036;
   logic [5:0]  cfg_lcr = 6'h03;
   logic [7:0]  cfg_fcr = 8'hC7;
   logic [3:0]  cfg_ier = 4'h5;
   logic [4:0]  cfg_mcr = 5'h03;
   logic        busy, done, err, psel, penable, pwrite, pready, pslverr;
   logic [1:0]  err_code;
   logic [2:0]  err_step;
   logic [7:0]  paddr;
   logic [31:0] pwdata, prdata;

   int errors = 0;
   int checks = 0;

   int wait_step = -1, wait_n = 0, slverr_step = -1, hang_step = -1;
   bit bad_dll = 1'b0;
   int acc_cnt, wr_count, cur_step;
   logic [7:0] regs [8];
   logic [7:0] rd_byte;
   xfer_t exp_q[$], obs_q[$];
   int offs [7] = '{3, 0, 1, 3, 2, 1, 4};

   always #5 clk = ~clk;

   uart_cfg_ctrl dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_div(cfg_div),
      .cfg_lcr(cfg_lcr), .cfg_fcr(cfg_fcr), .cfg_ier(cfg_ier), .cfg_mcr(cfg_mcr),
      .busy(busy), .done(done), .err(err), .err_code(err_code), .err_step(err_step),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   // Behavioural UART register port
   always_comb begin
      cur_step = pwrite ? wr_count : wr_count - 1;
      pready   = psel && penable && !(pwrite && cur_step == hang_step) &&
                 (acc_cnt >= ((pwrite && cur_step == wait_step) ? wait_n : 0));
      pslverr  = pready && pwrite && (cur_step == slverr_step);
      rd_byte  = regs[paddr[4:2]];
      if (bad_dll && paddr == 8'd0) rd_byte = 8'h37;
      prdata   = {24'd0, rd_byte};
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_cnt  <= 0;
         wr_count <= 0;
      end else begin
         if (cfg_start && !busy) wr_count <= 0;
         else if (psel && penable && pready && pwrite) wr_count <= wr_count + 1;
         if (psel && !penable) acc_cnt <= 0;
         else if (psel && penable) acc_cnt <= pready ? 0 : acc_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (!rst && psel && penable && pready) begin
         if (pwrite) regs[paddr[4:2]] <= pwdata[7:0];
         obs_q.push_back({pwrite, paddr, pwrite ? pwdata : prdata});
      end
   end

   function automatic logic [7:0] model_data(input int s);
      case (s)
         0:       return 8'h80 | {2'b00, cfg_lcr};
         1:       return cfg_div[7:0];
         2:       return cfg_div[15:8];
         3:       return {2'b00, cfg_lcr};
         4:       return cfg_fcr;
         5:       return {4'h0, cfg_ier};
         default: return {3'b000, cfg_mcr};
      endcase
   endfunction

   task automatic push_seq(input int upto, input bit last_read);
      for (int s = 0; s <= upto; s++) begin
         exp_q.push_back({1'b1, 8'(offs[s] * 4), {24'd0, model_data(s)}});
         if (RB == 1 && s != 4 && (s < upto || last_read))
            exp_q.push_back({1'b0, 8'(offs[s] * 4), 32'd0});
      end
   endtask

   task automatic do_start();
      @(posedge clk); #1;
      obs_q.delete();
      exp_q.delete();
      cfg_start = 1'b1;
   endtask

   // Runs until the sequencer returns to idle; holds cfg_start for the first
   // cycles so that starts while busy are exercised too.
   task automatic run_seq(output int done_at, output int end_at, output int unstable,
                          output int max_acc, output logic err_at1);
      int acc;
      logic [7:0] la;
      logic [31:0] ld;
      done_at = -1; end_at = -1; unstable = 0; max_acc = 0; acc = 0;
      la = 8'd0; ld = 32'd0; err_at1 = 1'bx;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         if (n >= 3) cfg_start = 1'b0;
         if (n == 1) err_at1 = err;
         if (psel && !penable) begin
            la = paddr; ld = pwdata; acc = 0;
         end else if (psel && penable) begin
            acc++;
            if (acc > max_acc) max_acc = acc;
            if (paddr !== la || pwdata !== ld) unstable++;
         end
         if (done) done_at = n;
         if (!busy) begin
            end_at = n;
            break;
         end
      end
      cfg_start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, err, err_code, err_step, psel, penable, pwrite, paddr, pwdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b err=%b code=%b step=%0d psel=%b pen=%b pw=%b addr=%h wd=%h want all 0",
                  busy, done, err, err_code, err_step, psel, penable, pwrite, paddr, pwdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
      $display("reset: done");
   endtask

   task automatic test_nominal();
      int da, ea, un, ma;
      logic e1;
      do_start();
      push_seq(6, 1'b1);
      run_seq(da, ea, un, ma, e1);
      checks++;
      if (da !== 15 + 12 * RB) begin errors++; $display("FAIL nominal_done_cycle got %0d want %0d", da, 15 + 12 * RB); end
      checks++;
      if (ea !== da + 1) begin errors++; $display("FAIL nominal_done_pulse got end=%0d want %0d", ea, da + 1); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL nominal_err got %b want 0", err); end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL nominal_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         xfer_t o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o.w !== e.w || o.addr !== e.addr || (e.w && o.data !== e.data)) begin
            errors++;
            $display("FAIL nominal_xfer got w=%b a=%h d=%h want w=%b a=%h d=%h", o.w, o.addr, o.data, e.w, e.addr, e.data);
         end
      end
      $display("nominal: done at cycle %0d", da);
   endtask

   task automatic test_wait_states();
      int da, ea, un, ma;
      logic e1;
      wait_step = 2; wait_n = 3;
      do_start();
      push_seq(6, 1'b1);
      run_seq(da, ea, un, ma, e1);
      wait_step = -1;
      checks++;
      if (un !== 0) begin errors++; $display("FAIL wait_stable got %0d changes want 0", un); end
      checks++;
      if (ma !== 4) begin errors++; $display("FAIL wait_access_len got %0d want 4", ma); end
      checks++;
      if (da !== 18 + 12 * RB) begin errors++; $display("FAIL wait_done_cycle got %0d want %0d", da, 18 + 12 * RB); end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL wait_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         xfer_t o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o.w !== e.w || o.addr !== e.addr || (e.w && o.data !== e.data)) begin
            errors++;
            $display("FAIL wait_xfer got w=%b a=%h d=%h want w=%b a=%h d=%h", o.w, o.addr, o.data, e.w, e.addr, e.data);
         end
      end
      $display("wait_states: done at cycle %0d", da);
   endtask

   task automatic test_slverr();
      int da, ea, un, ma;
      logic e1;
      slverr_step = 5;
      cfg_div = 16'h1234; cfg_lcr = 6'h1B; cfg_ier = 4'hA; cfg_mcr = 5'h11;
      do_start();
      push_seq(5, 1'b0);
      run_seq(da, ea, un, ma, e1);
      slverr_step = -1;
      checks++;
      if ({err, err_code, err_step} !== {1'b1, 2'b01, 3'd5}) begin
         errors++; $display("FAIL slverr_status got err=%b code=%b step=%0d want 1/01/5", err, err_code, err_step);
      end
      checks++;
      if (da !== -1) begin errors++; $display("FAIL slverr_no_done got done at %0d want none", da); end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL slverr_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         xfer_t o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o.w !== e.w || o.addr !== e.addr || (e.w && o.data !== e.data)) begin
            errors++;
            $display("FAIL slverr_xfer got w=%b a=%h d=%h want w=%b a=%h d=%h", o.w, o.addr, o.data, e.w, e.addr, e.data);
         end
      end
      do_start();
      run_seq(da, ea, un, ma, e1);
      checks++;
      if (e1 !== 1'b0) begin errors++; $display("FAIL slverr_err_clear got %b want 0", e1); end
      checks++;
      if (da !== 15 + 12 * RB || err !== 1'b0) begin
         errors++; $display("FAIL slverr_restart got done=%0d err=%b want %0d/0", da, err, 15 + 12 * RB);
      end
      cfg_div = 16'h0036; cfg_lcr = 6'h03; cfg_ier = 4'h5; cfg_mcr = 5'h03;
      $display("slverr: code=%b step=%0d", err_code, err_step);
   endtask

   task automatic test_timeout();
      int da, ea, un, ma;
      logic e1;
      hang_step = 0;
      do_start();
      run_seq(da, ea, un, ma, e1);
      hang_step = -1;
      checks++;
      if (ma !== 16) begin errors++; $display("FAIL timeout_access_len got %0d want 16", ma); end
      checks++;
      if (ea !== 19) begin errors++; $display("FAIL timeout_idle_cycle got %0d want 19", ea); end
      checks++;
      if ({err, err_code, err_step} !== {1'b1, 2'b10, 3'd0}) begin
         errors++; $display("FAIL timeout_status got err=%b code=%b step=%0d want 1/10/0", err, err_code, err_step);
      end
      checks++;
      if (obs_q.size() !== 0 || psel !== 1'b0) begin
         errors++; $display("FAIL timeout_bus got xfers=%0d psel=%b want 0/0", obs_q.size(), psel);
      end
      $display("timeout: code=%b step=%0d", err_code, err_step);
   endtask

`ifdef UART_CFG_READBACK_EN
   task automatic test_readback();
      int da, ea, un, ma;
      logic e1;
      bad_dll = 1'b1;
      do_start();
      run_seq(da, ea, un, ma, e1);
      bad_dll = 1'b0;
      checks++;
      if ({err, err_code, err_step} !== {1'b1, 2'b11, 3'd1}) begin
         errors++; $display("FAIL readback_status got err=%b code=%b step=%0d want 1/11/1", err, err_code, err_step);
      end
      checks++;
      if (obs_q.size() !== 4 || da !== -1) begin
         errors++; $display("FAIL readback_xfers got %0d done=%0d want 4/-1", obs_q.size(), da);
      end
      $display("readback: code=%b step=%0d", err_code, err_step);
   endtask
`endif

   task automatic test_reset_mid();
      int da, ea, un, ma;
      logic e1;
      bit hit;
      hit = 1'b0;
      do_start();
      for (int n = 0; n < 100; n++) begin
         @(posedge clk); #1;
         cfg_start = 1'b0;
         if (wr_count == 3 && psel && !penable) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL reset_mid_reach got no step3 setup want one"); end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, err, err_code, err_step, psel, penable, pwrite, paddr, pwdata} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs got busy=%b psel=%b pen=%b pw=%b addr=%h wd=%h want all 0",
                  busy, psel, penable, pwrite, paddr, pwdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      do_start();
      push_seq(6, 1'b1);
      run_seq(da, ea, un, ma, e1);
      checks++;
      if (da !== 15 + 12 * RB) begin errors++; $display("FAIL reset_mid_restart got %0d want %0d", da, 15 + 12 * RB); end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL reset_mid_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         xfer_t o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o.w !== e.w || o.addr !== e.addr || (e.w && o.data !== e.data)) begin
            errors++;
            $display("FAIL reset_mid_xfer got w=%b a=%h d=%h want w=%b a=%h d=%h", o.w, o.addr, o.data, e.w, e.addr, e.data);
         end
      end
      $display("reset_mid: restart done at cycle %0d", da);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) regs[i] = 8'h00;
      test_reset();
      test_nominal();
      test_wait_states();
      test_slverr();
      test_timeout();
`ifdef UART_CFG_READBACK_EN
      test_readback();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
